dinorun_game_ctrl: RTL and testbench
====================================

// Module: dinorun_game_ctrl
// PURPOSE
//  Parametrised game-control FSM for dinorun: owns title/play/pause/hit/game-over sequencing,
//  collision latching, N obstacle spawn channels with cooldown, lives, and a BCD score with high score.
//  Sits between vga_timer/edge_detector/lfsr16 and the dino/obstacle objects; drives freeze and spawn.
// PARAMETERS
//  NUM_OBST    2   number of obstacle channels (1..4)
//  DIGITS      4   BCD score digits
//  LIVES       3   lives per game (1..7)
//  SPAWN_BITS  5   spawn chance per channel per frame = 2^-SPAWN_BITS
//  MIN_GAP     30  frames of global spawn cooldown after any spawn
//  HIT_FRAMES  60  frames frozen in HIT before resuming or ending
//  SPEED_FRAMES 600 frames per speed level increment; MAX_SPEED 7
// PORTS
//  clk_i          in  1           pixel clock
//  rst_ni         in  1           async active-low reset
//  start_i        in  1           start/restart button (level)
//  pause_i        in  1           pause toggle button (level)
//  next_frame_i   in  1           1-cycle pulse, start of vertical blanking
//  visible_i      in  1           current pixel is in the visible area
//  dino_pixel_i   in  1           dino covers current pixel
//  obst_pixel_i   in  NUM_OBST    obstacle k covers current pixel
//  rand_i         in  16          lfsr16 output
//  spawn_o        out NUM_OBST    1-cycle spawn pulse for obstacle k
//  freeze_o       out 1           objects hold position
//  hit_o          out 1           dino shows hit sprite
//  title_en_o     out 1           title overlay enabled
//  lfsr_en_o      out 1           advance LFSR
//  speed_o        out 3           current speed level to obstacles
//  lives_o        out 3           remaining lives
//  score_o        out 4*DIGITS    BCD score, digit 0 in [3:0]
//  high_o         out 4*DIGITS    BCD high score
//  digit_en_o     out DIGITS      per-digit enable, leading zeros blanked (digit 0 always on)
// BEHAVIOUR
//  Reset: state TITLE; score, high, speed 0; lives=LIVES; spawn_o 0; freeze_o 0; hit_o 0; title_en_o 1; cooldown 0.
//  Two-flop sync + rising-edge detect on start_i and pause_i; only edges act ("start", "pause").
//  States (enum game_state_t): TITLE, PLAYING, PAUSED, HIT, GAMEOVER.
//  TITLE: title_en_o=1, no spawns, score held 0; start -> PLAYING (score, speed, cooldown cleared, lives=LIVES).
//  PLAYING: score +1 (BCD, ripple carry) per next_frame_i; saturates at all-9s, no wrap.
//   Collision: latch sets when visible_i & dino_pixel_i & |obst_pixel_i; evaluated at next_frame_i:
//   latched -> lives-1, hit_o=1, -> HIT; latch clears every next_frame_i. pause -> PAUSED.
//   Speed: frame counter; every SPEED_FRAMES frames speed_o+1, saturating at MAX_SPEED.
//  PAUSED: freeze_o=1, score/speed/cooldown frozen, latch ignored; pause -> PLAYING; start ignored.
//  HIT: freeze_o=1, hit_o=1, counts HIT_FRAMES frames; at expiry lives>0 -> PLAYING (hit_o 0),
//   lives==0 -> GAMEOVER. start/pause ignored during HIT.
//  GAMEOVER: freeze_o=1, hit_o=1; on entry high <= score if score > high (one cycle after entry);
//   start -> PLAYING as from TITLE (high kept).
//  Spawn (PLAYING only): on cycle of next_frame_i, if cooldown==0, candidate k when
//   rand_i[4k +: SPAWN_BITS]==0 (index wraps mod 16); lowest k wins, at most one pulse per frame;
//   spawning loads cooldown=MIN_GAP, decremented per next_frame_i in PLAYING.
//  Pause and collision on same next_frame_i: collision wins (-> HIT).
//  lfsr_en_o=1 in all states except PAUSED.
//  Outputs registered; spawn/hit decisions visible cycle after next_frame_i.
//  Mid-game reset: immediate return to reset values, including high score.
// STRUCTURE
//  dinorun_pkg: game_state_t, MAX_SPEED, default spawn/cooldown constants.
//  Sub-module bcd_counter (param DIGITS; en_i, clr_i, saturating) instanced for score.
//  High-score compare: combinational BCD magnitude compare MSD first.
// TESTING
//  Reset, start pulse -> PLAYING next cycle; 12 frames -> score_o=0x0012, digit_en_o=4'b0011.
//  Force overlap 1 pixel in frame, LIVES=3 -> at next_frame lives_o=2, HIT; 60 frames later PLAYING.
//  3 hits -> GAMEOVER, high_o=score_o; restart, lower score -> high_o unchanged.
//  rand_i=16'h0000 every frame, MIN_GAP=30 -> spawn_o=01 once, then next spawn exactly 30 frames later.
//  Pause edge -> freeze_o=1, score held for 100 frames; held-high pause_i does not re-toggle.
//  Score preload 9999 -> stays 9999; SPEED_FRAMES=4 -> speed_o saturates at 7 after 28 frames.

Source files
------------

// File: rtl/dinorun_pkg.sv
// dinorun_pkg: shared game state type and default timing constants for dinorun
package dinorun_pkg;
  typedef enum logic [2:0] {TITLE, PLAYING, PAUSED, HIT, GAMEOVER} game_state_t;
  localparam logic [2:0] MAX_SPEED = 3'd7;
  localparam int DEF_SPAWN_BITS = 5;
  localparam int DEF_MIN_GAP = 30;
  localparam int DEF_HIT_FRAMES = 60;
  localparam int DEF_SPEED_FRAMES = 600;
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD up-counter with synchronous clear, saturating at all nines
module bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   count_o
);
  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] w_next;
  logic                w_carry;
  // w_carry surviving every digit means the count is all nines and must hold
  always_comb begin
    w_next = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        w_carry = r_count[4*i +: 4] == 4'd9;
        w_next[4*i +: 4] = w_carry ? 4'd0 : r_count[4*i +: 4] + 4'd1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_count <= '0;
    else if (clr_i) r_count <= '0;
    else if (en_i && !w_carry) r_count <= w_next;
  end
  assign count_o = r_count;
endmodule

// File: rtl/dinorun_game_ctrl.sv
// dinorun_game_ctrl: game sequencing FSM with collision latch, spawn cooldown, lives,
// speed levels and BCD score / high score for the dinorun display pipeline.
module dinorun_game_ctrl
  import dinorun_pkg::*;
#(
  parameter int NUM_OBST     = 2,
  parameter int DIGITS       = 4,
  parameter int LIVES        = 3,
  parameter int SPAWN_BITS   = DEF_SPAWN_BITS,
  parameter int MIN_GAP      = DEF_MIN_GAP,
  parameter int HIT_FRAMES   = DEF_HIT_FRAMES,
  parameter int SPEED_FRAMES = DEF_SPEED_FRAMES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  pause_i,
  input  logic                  next_frame_i,
  input  logic                  visible_i,
  input  logic                  dino_pixel_i,
  input  logic [NUM_OBST-1:0]   obst_pixel_i,
  input  logic [15:0]           rand_i,
  output logic [NUM_OBST-1:0]   spawn_o,
  output logic                  freeze_o,
  output logic                  hit_o,
  output logic                  title_en_o,
  output logic                  lfsr_en_o,
  output logic [2:0]            speed_o,
  output logic [2:0]            lives_o,
  output logic [4*DIGITS-1:0]   score_o,
  output logic [4*DIGITS-1:0]   high_o,
  output logic [DIGITS-1:0]     digit_en_o
);
  localparam int CW = $clog2(MIN_GAP + 1);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int FW = $clog2(SPEED_FRAMES + 1);
  localparam logic [15:0] SPAWN_MASK = 16'((1 << SPAWN_BITS) - 1);

  game_state_t         r_state;
  logic [1:0]          r_start_s, r_pause_s;
  logic                r_start_d, r_pause_d;
  logic                r_coll;
  logic [CW-1:0]       r_cool;
  logic [HW-1:0]       r_hcnt;
  logic [FW-1:0]       r_fcnt;
  logic [4*DIGITS-1:0] r_high;
  logic [NUM_OBST-1:0] r_spawn;
  logic                r_freeze, r_hit, r_title, r_lfsr;
  logic [2:0]          r_speed, r_lives;

  logic                w_start, w_pause, w_overlap, w_gt, w_acc;
  logic [CW-1:0]       w_cool_nxt;
  logic [NUM_OBST-1:0] w_spawn;
  logic [15:0]         w_rot;
  logic [4*DIGITS-1:0] w_score;
  logic [DIGITS-1:0]   w_den;

  assign w_start    = r_start_s[1] & ~r_start_d;
  assign w_pause    = r_pause_s[1] & ~r_pause_d;
  assign w_overlap  = visible_i & dino_pixel_i & |obst_pixel_i;
  assign w_cool_nxt = (r_cool == '0) ? '0 : r_cool - CW'(1);
  assign w_gt       = w_score > r_high;

  bcd_counter #(.DIGITS(DIGITS)) u_score (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    ((r_state == PLAYING) && next_frame_i),
    .clr_i   (w_start && (r_state == TITLE || r_state == GAMEOVER)),
    .count_o (w_score)
  );

  // channel k tests a SPAWN_BITS window starting at bit 4k, wrapping round the 16-bit word
  always_comb begin
    w_spawn = '0;
    w_rot = '0;
    for (int k = 0; k < NUM_OBST; k++) begin
      w_rot = (rand_i >> (4 * k)) | (rand_i << (16 - 4 * k));
      if (w_spawn == '0 && (w_rot & SPAWN_MASK) == '0) w_spawn[k] = 1'b1;
    end
  end

  always_comb begin
    w_den = '0;
    w_acc = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_acc = w_acc | (w_score[4*i +: 4] != 4'd0);
      w_den[i] = w_acc;
    end
    w_den[0] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= TITLE;
      r_start_s <= '0;
      r_pause_s <= '0;
      r_start_d <= 1'b0;
      r_pause_d <= 1'b0;
      r_coll    <= 1'b0;
      r_cool    <= '0;
      r_hcnt    <= '0;
      r_fcnt    <= '0;
      r_high    <= '0;
      r_spawn   <= '0;
      r_freeze  <= 1'b0;
      r_hit     <= 1'b0;
      r_title   <= 1'b1;
      r_lfsr    <= 1'b1;
      r_speed   <= '0;
      r_lives   <= 3'(LIVES);
    end else begin
      r_start_s <= {r_start_s[0], start_i};
      r_pause_s <= {r_pause_s[0], pause_i};
      r_start_d <= r_start_s[1];
      r_pause_d <= r_pause_s[1];
      r_spawn   <= '0;
      if (next_frame_i) r_coll <= 1'b0;
      else if (r_state == PLAYING && w_overlap) r_coll <= 1'b1;
      case (r_state)
        TITLE, GAMEOVER: begin
          if (r_state == GAMEOVER && w_gt) r_high <= w_score;
          if (w_start) begin
            r_state  <= PLAYING;
            r_title  <= 1'b0;
            r_freeze <= 1'b0;
            r_hit    <= 1'b0;
            r_lives  <= 3'(LIVES);
            r_speed  <= '0;
            r_fcnt   <= '0;
            r_cool   <= '0;
          end
        end
        PLAYING: begin
          if (next_frame_i && r_coll) begin
            r_state  <= HIT;
            r_lives  <= r_lives - 3'd1;
            r_hit    <= 1'b1;
            r_freeze <= 1'b1;
            r_hcnt   <= '0;
          end else begin
            // cooldown is decremented first so a spawn recurs exactly MIN_GAP frames later
            if (next_frame_i) begin
              r_cool  <= (w_cool_nxt == '0 && |w_spawn) ? CW'(MIN_GAP) : w_cool_nxt;
              r_spawn <= (w_cool_nxt == '0) ? w_spawn : '0;
              r_fcnt  <= (r_fcnt == FW'(SPEED_FRAMES - 1)) ? '0 : r_fcnt + FW'(1);
              if (r_fcnt == FW'(SPEED_FRAMES - 1) && r_speed != MAX_SPEED) r_speed <= r_speed + 3'd1;
            end
            if (w_pause) begin
              r_state  <= PAUSED;
              r_freeze <= 1'b1;
              r_lfsr   <= 1'b0;
            end
          end
        end
        PAUSED: begin
          if (w_pause) begin
            r_state  <= PLAYING;
            r_freeze <= 1'b0;
            r_lfsr   <= 1'b1;
          end
        end
        HIT: begin
          if (next_frame_i) begin
            if (r_hcnt == HW'(HIT_FRAMES - 1)) begin
              if (r_lives == '0) r_state <= GAMEOVER;
              else begin
                r_state  <= PLAYING;
                r_hit    <= 1'b0;
                r_freeze <= 1'b0;
              end
            end else r_hcnt <= r_hcnt + HW'(1);
          end
        end
        default: r_state <= TITLE;
      endcase
    end
  end

  assign spawn_o    = r_spawn;
  assign freeze_o   = r_freeze;
  assign hit_o      = r_hit;
  assign title_en_o = r_title;
  assign lfsr_en_o  = r_lfsr;
  assign speed_o    = r_speed;
  assign lives_o    = r_lives;
  assign score_o    = w_score;
  assign high_o     = r_high;
  assign digit_en_o = w_den;
endmodule

// File: tb/tb_dinorun_game_ctrl.sv
// tb_dinorun_game_ctrl: directed-vector bench for dinorun_game_ctrl (SPEED_FRAMES=4,
// other parameters at their defaults).
module tb_dinorun_game_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, pause = 1'b0, nf = 1'b0, vis = 1'b0, dino = 1'b0;
  logic [1:0]  obst = '0;
  logic [15:0] rnd = 16'hFFFF;
  logic [1:0]  spawn;
  logic        freeze, hit, title_en, lfsr_en;
  logic [2:0]  speed, lives;
  logic [15:0] score, high;
  logic [3:0]  digit_en;
  logic [1:0]  last_spawn;
  int          n_vec = 0, n_err = 0, n_early = 0;

  always #5 clk = ~clk;

  dinorun_game_ctrl #(.SPEED_FRAMES(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .pause_i      (pause),
    .next_frame_i (nf),
    .visible_i    (vis),
    .dino_pixel_i (dino),
    .obst_pixel_i (obst),
    .rand_i       (rnd),
    .spawn_o      (spawn),
    .freeze_o     (freeze),
    .hit_o        (hit),
    .title_en_o   (title_en),
    .lfsr_en_o    (lfsr_en),
    .speed_o      (speed),
    .lives_o      (lives),
    .score_o      (score),
    .high_o       (high),
    .digit_en_o   (digit_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    nf = 1'b1;
    tick(1);
    nf = 1'b0;
    last_spawn = spawn;
    tick(1);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press_start();
    start = 1'b1;
    tick(4);
    start = 1'b0;
    tick(2);
  endtask

  task automatic press_pause();
    pause = 1'b1;
    tick(4);
    pause = 1'b0;
    tick(2);
  endtask

  task automatic collide();
    vis = 1'b1;
    dino = 1'b1;
    obst = 2'b10;
    tick(1);
    vis = 1'b0;
    dino = 1'b0;
    obst = '0;
    frame();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_title", title_en, 1);
    check("rst_freeze", freeze, 0);
    check("rst_hit", hit, 0);
    check("rst_lives", lives, 3);
    check("rst_score", score, 0);
    check("rst_high", high, 0);
    check("rst_speed", speed, 0);
    check("rst_lfsr", lfsr_en, 1);
    check("rst_digits", digit_en, 4'b0001);
    frame();
    check("title_score_held", score, 0);
    check("title_no_spawn", last_spawn, 0);
    press_start();
    check("start_title_off", title_en, 0);
    check("start_freeze", freeze, 0);
    frames(12);
    check("score_12", score, 16'h0012);
    check("digits_12", digit_en, 4'b0011);
    check("speed_12", speed, 3);
    // first game: three hits, score ends at 15
    collide();
    check("hit1_score", score, 16'h0013);
    check("hit1_lives", lives, 2);
    check("hit1_hit", hit, 1);
    check("hit1_freeze", freeze, 1);
    frames(59);
    check("hit1_still_hit", hit, 1);
    check("hit1_score_frozen", score, 16'h0013);
    frame();
    check("hit1_resume_hit", hit, 0);
    check("hit1_resume_freeze", freeze, 0);
    collide();
    check("hit2_lives", lives, 1);
    frames(60);
    collide();
    check("hit3_lives", lives, 0);
    frames(60);
    tick(1);
    check("go_freeze", freeze, 1);
    check("go_hit", hit, 1);
    check("go_score", score, 16'h0015);
    check("go_high", high, 16'h0015);
    // second game: pause behaviour, then a lower final score
    press_start();
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    check("restart_high", high, 16'h0015);
    frames(5);
    check("g2_score5", score, 16'h0005);
    check("g2_speed5", speed, 1);
    pause = 1'b1;
    tick(4);
    check("pause_freeze", freeze, 1);
    check("pause_lfsr", lfsr_en, 0);
    frames(100);
    check("pause_score_held", score, 16'h0005);
    check("pause_held_no_toggle", freeze, 1);
    press_start();
    check("pause_start_ignored", freeze, 1);
    check("pause_start_score", score, 16'h0005);
    pause = 1'b0;
    tick(2);
    press_pause();
    check("unpause_freeze", freeze, 0);
    check("unpause_lfsr", lfsr_en, 1);
    frame();
    check("unpause_score", score, 16'h0006);
    check("unpause_speed", speed, 1);
    repeat (3) begin
      collide();
      frames(60);
    end
    tick(1);
    check("go2_score", score, 16'h0009);
    check("go2_high_kept", high, 16'h0015);
    check("go2_digits", digit_en, 4'b0001);
    // third game: spawn cooldown and speed saturation
    press_start();
    for (int i = 1; i <= 61; i++) begin
      rnd = (i <= 31) ? 16'h0000 : (i == 61) ? 16'hFE01 : 16'hFFFF;
      frame();
      if (i == 1) check("spawn_first", last_spawn, 2'b01);
      if (i >= 2 && i <= 30 && last_spawn != 0) n_early++;
      if (i == 31) check("spawn_gap30", last_spawn, 2'b01);
      if (i == 61) check("spawn_chan1", last_spawn, 2'b10);
      if (i == 27) check("speed_27", speed, 6);
      if (i == 28) check("speed_28", speed, 7);
    end
    check("spawn_cooldown_quiet", n_early, 0);
    check("speed_sat", speed, 7);
    rnd = 16'hFFFF;
    // pause edge and collision on the same frame: collision wins
    vis = 1'b1;
    dino = 1'b1;
    obst = 2'b01;
    tick(1);
    vis = 1'b0;
    dino = 1'b0;
    obst = '0;
    pause = 1'b1;
    tick(2);
    nf = 1'b1;
    tick(1);
    nf = 1'b0;
    pause = 1'b0;
    tick(1);
    check("pc_hit", hit, 1);
    check("pc_lfsr", lfsr_en, 1);
    check("pc_lives", lives, 2);
    frames(60);
    check("pc_resume_freeze", freeze, 0);
    check("pc_resume_lfsr", lfsr_en, 1);
    check("pc_score", score, 16'h0062);
    check("pc_digits", digit_en, 4'b0011);
    frames(10000);
    check("sat_score", score, 16'h9999);
    check("sat_digits", digit_en, 4'b1111);
    // asynchronous mid-game reset
    #2 rst_n = 1'b0;
    #1;
    check("arst_score", score, 0);
    check("arst_high", high, 0);
    check("arst_title", title_en, 1);
    check("arst_lives", lives, 3);
    check("arst_speed", speed, 0);
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
